// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder.
package sha256_pkg;

    localparam int CHUNK_W         = 512;
    localparam int BYTES_PER_CHUNK = 64;
    localparam int LEN_OFFSET      = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_LEN  = 2'd2,
        ST_EMIT = 2'd3
    } pad_state_e;

endpackage

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: collects a byte stream into 64-byte lanes, appends
// 0x80, zero fill and the 64-bit big-endian bit length, and hands out 512-bit
// chunks tagged first/last on a valid/ready handshake.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int CNT_W = 61
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic               in_empty,
    output logic               in_ready,
    output logic [CHUNK_W-1:0] chunk,
    output logic               chunk_valid,
    input  logic               chunk_ready,
    output logic               chunk_first,
    output logic               chunk_last
);

    // Length lanes sit at the tail of the chunk; lane k lives at r_buf[63-k],
    // so lane 0 lands in chunk[511:504] and the length field is r_buf[7:0].
    localparam int LEN_LANES = BYTES_PER_CHUNK - LEN_OFFSET;

    pad_state_e                            r_state;
    pad_state_e                            w_state_nxt;
    logic [BYTES_PER_CHUNK-1:0][7:0]       r_buf;
    logic [6:0]                            r_idx;
    logic [CNT_W-1:0]                      r_cnt;
    logic                                  r_pad_pend;
    logic                                  r_len_pend;
    logic                                  r_last;
    logic                                  r_first;
    logic                                  r_in_ready;
    logic                                  w_accept;
    logic                                  w_wr;
    logic                                  w_full;
    logic                                  w_hs;
    logic [LEN_LANES*8-1:0]                w_len;

    // Bit length of the message so far, truncated to the 64-bit field.
    assign w_len = 64'(r_cnt) << 3;

    assign in_ready    = r_in_ready;
    assign chunk       = r_buf;
    assign chunk_valid = (r_state == ST_EMIT);
    assign chunk_first = (r_state == ST_EMIT) && r_first;
    assign chunk_last  = (r_state == ST_EMIT) && r_last;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle strobes for the lane-write logic.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wr        = 1'b0;
        w_full      = 1'b0;
        w_hs        = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                w_accept = in_valid && r_in_ready;
                // An empty final beat ends the message without carrying a byte.
                w_wr     = w_accept && !(in_last && in_empty);
                w_full   = w_wr && (r_idx == 7'(BYTES_PER_CHUNK - 1));
                if (w_accept && in_last) begin
                    w_state_nxt = w_full ? ST_EMIT : ST_PAD;
                end else if (w_full) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_PAD:  w_state_nxt = ST_EMIT;
            ST_LEN:  w_state_nxt = ST_EMIT;
            ST_EMIT: begin
                w_hs = chunk_ready;
                if (chunk_ready) begin
                    if (r_pad_pend) begin
                        w_state_nxt = ST_PAD;
                    end else if (r_len_pend) begin
                        w_state_nxt = ST_LEN;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Lane writes, byte counter, pending-pad/length flags and chunk tags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_pad_pend <= 1'b0;
            r_len_pend <= 1'b0;
            r_last     <= 1'b0;
            r_first    <= 1'b1;
            r_in_ready <= 1'b0;
        end else begin
            // Registered so in_ready stays low while reset is held.
            r_in_ready <= (w_state_nxt == ST_FILL);
            unique case (r_state)
                ST_FILL: begin
                    if (w_wr) begin
                        r_buf[~r_idx[5:0]] <= in_data;
                        r_idx              <= r_idx + 7'd1;
                        r_cnt              <= r_cnt + CNT_W'(1);
                    end
                    // Final byte filled the chunk: the 0x80 goes in the next one.
                    if (w_accept && in_last && w_full) begin
                        r_pad_pend <= 1'b1;
                    end
                end
                ST_PAD: begin
                    r_buf[~r_idx[5:0]] <= PAD_BYTE;
                    if (r_idx < 7'(LEN_OFFSET)) begin
                        r_buf[LEN_LANES-1:0] <= w_len;
                        r_last               <= 1'b1;
                    end else begin
                        r_len_pend <= 1'b1;
                    end
                end
                ST_LEN: begin
                    r_buf[LEN_LANES-1:0] <= w_len;
                    r_last               <= 1'b1;
                end
                ST_EMIT: begin
                    if (w_hs) begin
                        // Clearing here makes zero fill free in later chunks.
                        r_buf      <= '0;
                        r_idx      <= '0;
                        r_pad_pend <= 1'b0;
                        r_len_pend <= 1'b0;
                        r_last     <= 1'b0;
                        r_first    <= r_last;
                        if (r_last) begin
                            r_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: reference padding model feeds a
// scoreboard queue that a handshake monitor drains and compares.
module tb_sha256_msg_padder;

    typedef struct packed {
        logic [511:0] data;
        logic         first;
        logic         last;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_empty;
    logic         in_ready;
    logic [511:0] chunk;
    logic         chunk_valid;
    logic         chunk_ready;
    logic         chunk_first;
    logic         chunk_last;

    int checks;
    int failures;
    exp_t exp_q[$];
    byte unsigned g_msg[$];
    bit rand_ready;
    bit ready_force;

    sha256_msg_padder #(.CNT_W(61)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_empty    (in_empty),
        .in_ready    (in_ready),
        .chunk       (chunk),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_first (chunk_first),
        .chunk_last  (chunk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: either forced level or random backpressure.
    initial begin
        chunk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            chunk_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Scoreboard monitor: every chunk handshake is compared with the model.
    always @(negedge clk) begin
        if (reset_n && chunk_valid && chunk_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL chunk_unexpected got=%h first=%0b last=%0b", chunk, chunk_first, chunk_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({chunk, chunk_first, chunk_last} !== {e.data, e.first, e.last}) begin
                    failures++;
                    $display("FAIL chunk got=%h f%0b l%0b want=%h f%0b l%0b",
                             chunk, chunk_first, chunk_last, e.data, e.first, e.last);
                end
            end
        end
    end

    // Reference FIPS 180-4 padding of g_msg, split into expected chunks.
    task automatic model_push();
        byte unsigned p[$];
        logic [63:0]  bl;
        exp_t         e;
        int           n;
        p  = g_msg;
        bl = 64'(g_msg.size()) << 3;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        n = p.size() / 64;
        for (int c = 0; c < n; c++) begin
            e.data = '0;
            for (int b = 0; b < 64; b++) e.data[511 - 8*b -: 8] = p[64*c + b];
            e.first = (c == 0);
            e.last  = (c == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Present one beat and hold it until accepted; returns at accept edge + 1.
    task automatic send_byte(input byte unsigned d, input bit last, input bit empty);
        int n;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 2000) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout got=0 want=1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic send_msg(input bit empty_tail);
        int sz;
        sz = g_msg.size();
        for (int i = 0; i < sz; i++) send_byte(g_msg[i], (i == sz - 1) && !empty_tail, 1'b0);
        if (sz == 0 || empty_tail) send_byte(8'h00, 1'b1, 1'b1);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
        rand_ready = 1'b0; ready_force = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, chunk_valid, chunk_first, chunk_last} !== 4'b0000 || chunk !== 512'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b want=0000", in_ready, chunk_valid, chunk_first, chunk_last);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL in_ready_before_edge got=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL in_ready_after_reset got=%b want=1", in_ready);
        end
    endtask

    task automatic test_abc();
        g_msg = {8'h61, 8'h62, 8'h63};
        model_push();
        send_msg(1'b0);
        checks++;
        if (chunk_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abc_pad_cycle got=v%b r%b want=v0 r0", chunk_valid, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({chunk_valid, chunk_first, chunk_last} !== 3'b111 ||
            chunk !== {32'h61626380, 416'h0, 64'h18}) begin
            failures++;
            $display("FAIL abc_chunk got=%h v%b f%b l%b want=61626380..18 v1 f1 l1",
                     chunk, chunk_valid, chunk_first, chunk_last);
        end
        drain(50);
    endtask

    task automatic test_empty();
        g_msg = {};
        model_push();
        send_msg(1'b0);
        @(posedge clk);
        #1;
        checks++;
        if ({chunk_valid, chunk_first, chunk_last} !== 3'b111 || chunk !== {8'h80, 504'h0}) begin
            failures++;
            $display("FAIL empty_chunk got=%h v%b f%b l%b want=80..00 v1 f1 l1",
                     chunk, chunk_valid, chunk_first, chunk_last);
        end
        drain(50);
    endtask

    task automatic test_boundaries();
        int lens[6] = '{55, 56, 63, 64, 119, 120};
        for (int k = 0; k < 6; k++) begin
            g_msg = {};
            for (int i = 0; i < lens[k]; i++) g_msg.push_back(8'h61);
            model_push();
            send_msg(1'b0);
            drain(300);
        end
        g_msg = {8'h61, 8'h62, 8'h63};
        model_push();
        send_msg(1'b1);
        drain(50);
    endtask

    task automatic test_stall();
        exp_t snap;
        int   n;
        ready_force = 1'b0;
        g_msg = {8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
        model_push();
        send_msg(1'b0);
        n = 0;
        while (!chunk_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        snap.data = chunk; snap.first = chunk_first; snap.last = chunk_last;
        @(posedge clk);
        #1;
        in_data = 8'h78; in_last = 1'b1; in_empty = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (chunk_valid !== 1'b1 || in_ready !== 1'b0 ||
                {chunk, chunk_first, chunk_last} !== {snap.data, snap.first, snap.last}) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=v%b r%b f%b l%b want=v1 r0 f%b l%b",
                         c, chunk_valid, in_ready, chunk_first, chunk_last, snap.first, snap.last);
            end
        end
        g_msg = {8'h78};
        model_push();
        ready_force = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL stall_release got=in_ready0 want=1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        drain(50);
    endtask

    task automatic test_back_to_back();
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int len;
            bit et;
            len = $urandom_range(0, 140);
            et  = 1'($urandom_range(0, 1));
            g_msg = {};
            for (int i = 0; i < len; i++) g_msg.push_back(8'($urandom_range(0, 255)));
            model_push();
            send_msg(et);
        end
        drain(3000);
        rand_ready = 1'b0;
        ready_force = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 20; i++) send_byte(8'(i + 1), 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, chunk_valid, chunk_first, chunk_last} !== 4'b0000 || chunk !== 512'h0) begin
            failures++;
            $display("FAIL reset_mid_msg got=%b%b%b%b chunk=%h want=0000 zero",
                     in_ready, chunk_valid, chunk_first, chunk_last, chunk);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        g_msg = {8'h61, 8'h62, 8'h63};
        model_push();
        send_msg(1'b0);
        @(posedge clk);
        #1;
        checks++;
        if ({chunk_valid, chunk_first, chunk_last} !== 3'b111 ||
            chunk !== {32'h61626380, 416'h0, 64'h18}) begin
            failures++;
            $display("FAIL abc_after_reset got=%h v%b f%b l%b want=61626380..18 v1 f1 l1",
                     chunk, chunk_valid, chunk_first, chunk_last);
        end
        drain(50);
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        g_msg = {8'h61, 8'h62, 8'h63};
        model_push();
        send_msg(1'b0);
        n = 0;
        while (!chunk_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, chunk_valid, chunk_first, chunk_last} !== 4'b0000 || chunk !== 512'h0) begin
            failures++;
            $display("FAIL reset_mid_emit got=%b%b%b%b want=0000", in_ready, chunk_valid, chunk_first, chunk_last);
        end
        exp_q.delete();
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        g_msg = {8'h61};
        model_push();
        send_msg(1'b0);
        drain(50);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_abc();
        test_empty();
        test_boundaries();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
